seq_signed_div: RTL

//  Multi-cycle signed integer divider: inverse of the signed multiply path.

---
 rtl/seq_signed_div_if.sv | 27 ++
 rtl/seq_signed_div.sv | 112 +++++++++++
 2 files changed

// File: rtl/seq_signed_div_if.sv
// Handshake bundle for the sequential signed divider: operand channel in,
// result channel out, both valid/ready.
interface seq_signed_div_if #(
   parameter int DW = 8,
   parameter int VW = 4
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_zero;
   logic          ovf;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_zero, ovf
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_zero, ovf
   );
endinterface

// File: rtl/seq_signed_div.sv
// Multi-cycle signed divider: restoring division on magnitudes, one quotient
// bit per clock MSB first, then a sign fix-up into the registered result.
module seq_signed_div #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   seq_signed_div_if.slave bus
);
   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [DW-1:0] dq;        // dividend bits shift out the top, quotient bits shift in
   logic [VW-1:0] div_mag;
   logic [VW:0]   prem;
   logic          neg_q, neg_r, ovf_r;

   logic          accept, div_is_zero, last_step, q_bit;
   logic [DW:0]   dvd_abs;
   logic [VW:0]   div_abs, shifted, prem_nxt;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt    = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = div_is_zero ? DONE : CALC;
         end
         CALC: if (last_step) state_nxt = DONE;
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      accept      = bus.in_valid && (state == IDLE);
      div_is_zero = (bus.divisor == '0);
      last_step   = (cnt == CW'(DW - 1));
      // One extra bit so that the most negative operand has a representable magnitude.
      dvd_abs = bus.dividend[DW-1] ? -{bus.dividend[DW-1], bus.dividend}
                                   :  {bus.dividend[DW-1], bus.dividend};
      div_abs = bus.divisor[VW-1]  ? -{bus.divisor[VW-1], bus.divisor}
                                   :  {bus.divisor[VW-1], bus.divisor};
      shifted  = {prem[VW-1:0], dq[DW-1]};
      q_bit    = (shifted >= {1'b0, div_mag});
      prem_nxt = q_bit ? (shifted - {1'b0, div_mag}) : shifted;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         dq            <= '0;
         div_mag       <= '0;
         prem          <= '0;
         neg_q         <= 1'b0;
         neg_r         <= 1'b0;
         ovf_r         <= 1'b0;
         bus.quotient  <= '0;
         bus.remainder <= '0;
         bus.div_zero  <= 1'b0;
         bus.ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               if (div_is_zero) begin
                  bus.quotient  <= '0;
                  bus.remainder <= '0;
                  bus.div_zero  <= 1'b1;
                  bus.ovf       <= 1'b0;
               end else begin
                  dq      <= dvd_abs[DW-1:0];
                  div_mag <= div_abs[VW-1:0];
                  prem    <= '0;
                  cnt     <= '0;
                  neg_q   <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
                  neg_r   <= bus.dividend[DW-1];
                  ovf_r   <= (bus.dividend == {1'b1, {(DW-1){1'b0}}}) && (bus.divisor == '1);
               end
            end
            CALC: begin
               dq   <= {dq[DW-2:0], q_bit};
               prem <= prem_nxt;
               cnt  <= cnt + 1'b1;
               if (last_step) begin
                  cnt           <= '0;
                  bus.quotient  <= neg_q ? -{dq[DW-2:0], q_bit} : {dq[DW-2:0], q_bit};
                  bus.remainder <= neg_r ? -prem_nxt[VW-1:0] : prem_nxt[VW-1:0];
                  bus.div_zero  <= 1'b0;
                  bus.ovf       <= ovf_r;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
